// File: rtl/bram1be_arbiter.sv
// Two-requester round-robin arbiter for a single-ported byte-enable block RAM.
// Grants one access per cycle and steers read data back to the issuing requester.
module bram1be_arbiter #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int CHUNKSIZE  = 8,
  parameter int WE_WIDTH   = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  REQ_VALID0,
  output logic                  REQ_READY0,
  input  logic [WE_WIDTH-1:0]   REQ_WE0,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR0,
  input  logic [DATA_WIDTH-1:0] REQ_DI0,
  output logic                  RSP_VALID0,
  output logic [DATA_WIDTH-1:0] RSP_DATA0,

  input  logic                  REQ_VALID1,
  output logic                  REQ_READY1,
  input  logic [WE_WIDTH-1:0]   REQ_WE1,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR1,
  input  logic [DATA_WIDTH-1:0] REQ_DI1,
  output logic                  RSP_VALID1,
  output logic [DATA_WIDTH-1:0] RSP_DATA1,

  output logic                  BRAM_EN,
  output logic [WE_WIDTH-1:0]   BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int LAT = (PIPELINED != 0) ? 2 : 1;

  if (DATA_WIDTH != CHUNKSIZE * WE_WIDTH) begin : g_bad_width
    $error("bram1be_arbiter: DATA_WIDTH must equal CHUNKSIZE*WE_WIDTH");
  end

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  logic                  pri;
  tag_t [LAT-1:0]        tag_q;

  logic                  both_valid;
  logic                  grant_any;
  logic                  grant_sel;
  logic                  read_grant;
  logic [WE_WIDTH-1:0]   sel_we;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    both_valid = REQ_VALID0 & REQ_VALID1;
    // Grants are suppressed while RST is high so the RAM port stays idle.
    grant_any  = (REQ_VALID0 | REQ_VALID1) & ~RST;
    grant_sel  = both_valid ? pri : REQ_VALID1;
    sel_we     = grant_sel ? REQ_WE1 : REQ_WE0;
    read_grant = grant_any & (sel_we == '0);

    REQ_READY0 = grant_any & ~grant_sel;
    REQ_READY1 = grant_any &  grant_sel;

    BRAM_EN    = grant_any;
    BRAM_WE    = '0;
    BRAM_ADDR  = REQ_ADDR0;
    BRAM_DI    = REQ_DI0;
    if (grant_any) begin
      BRAM_WE = sel_we;
      if (grant_sel) begin
        BRAM_ADDR = REQ_ADDR1;
        BRAM_DI   = REQ_DI1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage of the
  // tag shift samples the pre-edge value of its neighbour.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pri   <= 1'b0;
      tag_q <= '0;
    end else begin
      if (both_valid) begin
        pri <= ~grant_sel;
      end
      tag_q[0] <= tag_t'{valid: read_grant, owner: grant_sel};
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Read data is shared; only the valid strobe identifies the owner.
  always_comb begin
    RSP_VALID0 = tag_q[LAT-1].valid & ~tag_q[LAT-1].owner;
    RSP_VALID1 = tag_q[LAT-1].valid &  tag_q[LAT-1].owner;
    RSP_DATA0  = BRAM_DO;
    RSP_DATA1  = BRAM_DO;
  end

endmodule
